// File: rtl/control_sequencer_if.sv
// Handshake and control bundle between a requester and control_sequencer.
// master drives start/op and observes status and datapath controls; slave is the sequencer.
interface control_sequencer_if;
    logic       start;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic       RAin;
    logic       RBin;
    logic       RZin;
    logic       RAout;
    logic       RBout;
    logic       RZout;

    modport master (
        output start, op,
        input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );

    modport slave (
        input  start, op,
        output busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer producing datapath load/drive strobes for LOADA, ADDA, MOVE and ACC.
// Defining SEQ_SINGLE_STEP_EN adds a step input that gates every advance out of T1, T2 and DONE.
module control_sequencer (
    input  logic clk,
    input  logic clear,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOADA = 2'b00;
    localparam logic [1:0] OP_ADDA  = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ACC   = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_op;
    logic       w_advance;
    logic       w_needs_t2;
    logic       w_busy, w_done;
    logic       w_ra_in, w_rb_in, w_rz_in;
    logic       w_ra_out, w_rb_out, w_rz_out;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_advance = step;
`else
    assign w_advance = 1'b1;
`endif

    assign w_needs_t2 = (r_op == OP_ADDA) || (r_op == OP_ACC);

    // op is captured only on acceptance so that later changes on the bus cannot disturb a sequence
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_op    <= OP_LOADA;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op <= bus.op;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_next = S_T1;
            S_T1:   if (w_advance) w_state_next = w_needs_t2 ? S_T2 : S_DONE;
            S_T2:   if (w_advance) w_state_next = S_DONE;
            S_DONE: if (w_advance) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Each state enables at most one source and one destination on the shared bus
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_ra_in  = 1'b0;
        w_rb_in  = 1'b0;
        w_rz_in  = 1'b0;
        w_ra_out = 1'b0;
        w_rb_out = 1'b0;
        w_rz_out = 1'b0;
        case (r_state)
            S_T1: begin
                w_busy = 1'b1;
                case (r_op)
                    OP_LOADA: w_ra_in = 1'b1;
                    OP_ADDA:  begin w_ra_out = 1'b1; w_rz_in = 1'b1; end
                    OP_MOVE:  begin w_ra_out = 1'b1; w_rb_in = 1'b1; end
                    OP_ACC:   begin w_rb_out = 1'b1; w_rz_in = 1'b1; end
                    default:  ;
                endcase
            end
            S_T2: begin
                w_busy   = 1'b1;
                w_rz_out = 1'b1;
                w_rb_in  = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.RAin  = w_ra_in;
    assign bus.RBin  = w_rb_in;
    assign bus.RZin  = w_rz_in;
    assign bus.RAout = w_ra_out;
    assign bus.RBout = w_rb_out;
    assign bus.RZout = w_rz_out;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a transaction-level model queues the expected
// per-cycle control words when a start is accepted; a monitor pops and compares every cycle.
module tb_control_sequencer;
    localparam logic [7:0] B_BUSY  = 8'h80;
    localparam logic [7:0] B_DONE  = 8'h40;
    localparam logic [7:0] B_RAIN  = 8'h20;
    localparam logic [7:0] B_RBIN  = 8'h10;
    localparam logic [7:0] B_RZIN  = 8'h08;
    localparam logic [7:0] B_RAOUT = 8'h04;
    localparam logic [7:0] B_RBOUT = 8'h02;
    localparam logic [7:0] B_RZOUT = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] got;
        logic [7:0] want;
    } dchk_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk   (clk),
        .clear (clear),
`ifdef SEQ_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    logic [7:0] exp_q[$];
    dchk_t      dir_q[$];
    int         total = 0;
    int         bad = 0;
    int         ntx = 0;
    int         m_rem = 0;
    logic       mon_en = 1'b0;
    logic [7:0] mon_got, mon_want;
    dchk_t      mon_d;

    // Tiny datapath driven by the sequencer's strobes; Z receives bus + RB
    logic       dp_load = 1'b0;
    logic [7:0] dp_ra = 8'd0, dp_rb = 8'd0, dp_rz = 8'd0;
    logic [7:0] dp_bus;
    always_comb begin
        dp_bus = 8'd0;
        if (bus.RAout)      dp_bus = dp_ra;
        else if (bus.RBout) dp_bus = dp_rb;
        else if (bus.RZout) dp_bus = dp_rz;
    end
    always @(posedge clk) begin
        if (dp_load) begin
            dp_ra <= 8'd5;
            dp_rb <= 8'd7;
            dp_rz <= 8'd0;
        end else begin
            if (bus.RAin) dp_ra <= dp_bus;
            if (bus.RBin) dp_rb <= dp_bus;
            if (bus.RZin) dp_rz <= dp_bus + dp_rb;
        end
    end

    function automatic logic [7:0] obs();
        return {bus.busy, bus.done, bus.RAin, bus.RBin, bus.RZin, bus.RAout, bus.RBout, bus.RZout};
    endfunction

    // Reference: operation table straight from the instruction semantics
    task automatic push_op(input logic [1:0] o, output int len);
        case (o)
            2'b00: exp_q.push_back(B_BUSY | B_RAIN);
            2'b01: exp_q.push_back(B_BUSY | B_RAOUT | B_RZIN);
            2'b10: exp_q.push_back(B_BUSY | B_RAOUT | B_RBIN);
            default: exp_q.push_back(B_BUSY | B_RBOUT | B_RZIN);
        endcase
        len = 2;
        if (o == 2'b01 || o == 2'b11) begin
            exp_q.push_back(B_BUSY | B_RZOUT | B_RBIN);
            len = 3;
        end
        exp_q.push_back(B_BUSY | B_DONE);
    endtask

    task automatic push_dir(input string n, input logic [7:0] g, input logic [7:0] w);
        dchk_t d;
        d.name = n;
        d.got  = g;
        d.want = w;
        dir_q.push_back(d);
    endtask

    // m_rem = busy cycles left starting with the current cycle
    task automatic drive_cycle(input logic s, input logic [1:0] o);
        int len;
        @(negedge clk);
        #1;
        bus.start = s;
        bus.op    = o;
        if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end else if (s) begin
            push_op(o, len);
            m_rem = len;
        end
    endtask

    always @(negedge clk) begin
        while (dir_q.size() > 0) begin
            mon_d = dir_q.pop_front();
            total = total + 1;
            if (mon_d.got !== mon_d.want) begin
                bad = bad + 1;
                $display("FAIL %s: got %h want %h", mon_d.name, mon_d.got, mon_d.want);
            end
        end
        if (mon_en) begin
            mon_got  = obs();
            mon_want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            total = total + 1;
            if (mon_got !== mon_want) begin
                bad = bad + 1;
                $display("FAIL ctrl_word @%0t: got %h want %h", $time, mon_got, mon_want);
            end else if (mon_want[6]) begin
                ntx = ntx + 1;
                $display("txn %0d complete @%0t", ntx, $time);
            end
            total = total + 1;
            if ($countones(mon_got[5:3]) > 1 || $countones(mon_got[2:0]) > 1) begin
                bad = bad + 1;
                $display("FAIL onehot @%0t: got %h want at most one in/out", $time, mon_got);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        push_dir("reset_outputs", obs(), 8'h00);
        @(negedge clk);
        #1;
        clear  = 1'b1;
        mon_en = 1'b1;

        // LOADA then idle
        drive_cycle(1'b1, 2'b00);
        repeat (3) drive_cycle(1'b0, 2'b00);

        // ADDA on the datapath: RA=5, RB=7 -> RB=12
        dp_load = 1'b1;
        drive_cycle(1'b0, 2'b00);
        dp_load = 1'b0;
        drive_cycle(1'b1, 2'b01);
        repeat (3) drive_cycle(1'b0, 2'b00);
        push_dir("adda_rb", dp_rb, 8'd12);

        // start held high while op wanders
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 2'($urandom_range(0, 3)));

        // abort ACC during T2
        while (m_rem > 0) drive_cycle(1'b0, 2'b00);
        drive_cycle(1'b1, 2'b11);
        drive_cycle(1'b0, 2'b00);
        drive_cycle(1'b0, 2'b00);
        clear = 1'b0;
        #1;
        push_dir("abort_outputs", obs(), 8'h00);
        exp_q.delete();
        m_rem = 0;
        @(negedge clk);
        #1;
        clear = 1'b1;
        repeat (4) drive_cycle(1'b0, 2'b11);

        // random stream
        for (int i = 0; i < 10000; i++) drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

`ifdef SEQ_SINGLE_STEP_EN
        while (m_rem > 0) drive_cycle(1'b0, 2'b00);
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        step      = 1'b0;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_dir("step_hold_t1", obs(), B_BUSY | B_RBOUT | B_RZIN);
            @(negedge clk);
            #1;
            if (i == 3) step = 1'b1;
        end
        step = 1'b0;
        push_dir("step_t2", obs(), B_BUSY | B_RZOUT | B_RBIN);
        step = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        mon_en = 1'b1;
`endif

        repeat (6) drive_cycle(1'b0, 2'b00);
        repeat (2) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
